// File: rtl/ddr_pkg.sv
// Shared types and constants for the HDR-DDR frame tracker.
package ddr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    localparam logic MODE_SDR = 1'b0;
    localparam logic MODE_DDR = 1'b1;

    // 2 preamble + 16 data + 2 parity
    localparam int DEF_DDR_WORD_BITS = 20;
    // 8 data + T bit
    localparam int DEF_SDR_WORD_BITS = 9;

endpackage

// File: rtl/ddr_frame_tracker_if.sv
// Control and status bundle between the mode FSM (master) and the tracker (slave).
interface ddr_frame_tracker_if #(
    parameter int LEN_W = 16,
    parameter int CNT_W = 5
);
    logic             i_en;
    logic             i_mode;
    logic [LEN_W-1:0] i_data_len;
    logic             i_scl_pos_edge;
    logic             i_scl_neg_edge;
    logic             i_err_rst;
    logic [CNT_W-1:0] o_bit_count;
    logic [LEN_W-1:0] o_word_count;
    logic             o_word_done;
    logic             o_last_word;
    logic             o_xfer_done;
    logic             o_len_err;
    logic             o_busy;

    modport master (
        output i_en, i_mode, i_data_len, i_scl_pos_edge, i_scl_neg_edge, i_err_rst,
        input  o_bit_count, o_word_count, o_word_done, o_last_word, o_xfer_done,
               o_len_err, o_busy
    );

    modport slave (
        input  i_en, i_mode, i_data_len, i_scl_pos_edge, i_scl_neg_edge, i_err_rst,
        output o_bit_count, o_word_count, o_word_done, o_last_word, o_xfer_done,
               o_len_err, o_busy
    );
endinterface

// File: rtl/ddr_word_len_calc.sv
// Converts a byte length into a word count for the selected bus mode.
// DDR words carry two bytes, so the count is ceil(len/2), formed as
// (len>>1) + len[0] so the all-ones length cannot overflow LEN_W bits.
module ddr_word_len_calc
    import ddr_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             mode,
    input  logic [LEN_W-1:0] data_len,
    output logic [LEN_W-1:0] words_total
);

    logic [LEN_W-1:0] half_up;

    // Word count selection by mode
    always_comb begin
        half_up     = {1'b0, data_len[LEN_W-1:1]} + LEN_W'(data_len[0]);
        words_total = (mode == MODE_DDR) ? half_up : data_len;
    end

endmodule

// File: rtl/ddr_frame_tracker.sv
// Bit/word position tracker for SDR and DDR transfers.
//
// state    | meaning
// ST_IDLE  | waiting for a fresh i_en with i_en seen low since the last run
// ST_COUNT | counting SCL edges; o_busy high
// ST_DONE  | one cycle: o_xfer_done and final o_word_done
// ST_ERR   | one cycle: o_len_err after a zero-length start
module ddr_frame_tracker
    import ddr_pkg::*;
#(
    parameter int DDR_WORD_BITS = DEF_DDR_WORD_BITS,
    parameter int SDR_WORD_BITS = DEF_SDR_WORD_BITS,
    parameter int LEN_W         = 16,
    parameter int CNT_W         = 5
) (
    input  logic               i_sys_clk,
    input  logic               i_sys_rst,
    ddr_frame_tracker_if.slave bus
);

    localparam logic [CNT_W-1:0] DDR_LAST_BIT = CNT_W'(DDR_WORD_BITS - 1);
    localparam logic [CNT_W-1:0] SDR_LAST_BIT = CNT_W'(SDR_WORD_BITS - 1);

    state_t           state;
    logic             mode_q;
    logic [LEN_W-1:0] total_q;
    logic [LEN_W-1:0] word_q;
    logic [CNT_W-1:0] bit_q;
    logic             busy_q;
    logic             word_done_q;
    logic             xfer_done_q;
    logic             len_err_q;
    // Set once i_en has been low; a held i_en cannot start a second run.
    logic             armed_q;

    logic [LEN_W-1:0] calc_total;
    logic [LEN_W-1:0] last_word_idx;
    logic [CNT_W-1:0] last_bit;
    logic             scl_edge;

    ddr_word_len_calc #(
        .LEN_W (LEN_W)
    ) u_len_calc (
        .mode        (bus.i_mode),
        .data_len    (bus.i_data_len),
        .words_total (calc_total)
    );

    // Mode-dependent counting edge and word geometry from latched values
    always_comb begin
        scl_edge      = (mode_q == MODE_DDR) ? (bus.i_scl_pos_edge | bus.i_scl_neg_edge)
                                             : bus.i_scl_pos_edge;
        last_bit      = (mode_q == MODE_DDR) ? DDR_LAST_BIT : SDR_LAST_BIT;
        last_word_idx = total_q - LEN_W'(1);
    end

    // Transfer FSM with counters and registered strobes
    always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
        if (!i_sys_rst) begin
            state       <= ST_IDLE;
            mode_q      <= MODE_SDR;
            total_q     <= '0;
            word_q      <= '0;
            bit_q       <= '0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
            xfer_done_q <= 1'b0;
            len_err_q   <= 1'b0;
            armed_q     <= 1'b1;
        end else begin
            word_done_q <= 1'b0;
            xfer_done_q <= 1'b0;
            len_err_q   <= 1'b0;
            if (!bus.i_en) begin
                armed_q <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (armed_q && bus.i_en && (bus.i_data_len == '0)) begin
                        state     <= ST_ERR;
                        len_err_q <= 1'b1;
                        armed_q   <= 1'b0;
                    end else if (armed_q && bus.i_en && !bus.i_err_rst) begin
                        state   <= ST_COUNT;
                        busy_q  <= 1'b1;
                        mode_q  <= bus.i_mode;
                        total_q <= calc_total;
                        bit_q   <= '0;
                        word_q  <= '0;
                        armed_q <= 1'b0;
                    end
                end

                ST_COUNT: begin
                    // Abort wins over any edge in the same cycle.
                    if (!bus.i_en || bus.i_err_rst) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        bit_q  <= '0;
                        word_q <= '0;
                    end else if (scl_edge) begin
                        if (bit_q < last_bit) begin
                            bit_q <= bit_q + CNT_W'(1);
                        end else begin
                            bit_q       <= '0;
                            word_done_q <= 1'b1;
                            if (word_q < last_word_idx) begin
                                word_q <= word_q + LEN_W'(1);
                            end else begin
                                state       <= ST_DONE;
                                busy_q      <= 1'b0;
                                xfer_done_q <= 1'b1;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    state  <= ST_IDLE;
                    bit_q  <= '0;
                    word_q <= '0;
                end

                ST_ERR: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_bit_count  = bit_q;
    assign bus.o_word_count = word_q;
    assign bus.o_word_done  = word_done_q;
    assign bus.o_xfer_done  = xfer_done_q;
    assign bus.o_len_err    = len_err_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_last_word  = busy_q && (word_q == last_word_idx);

endmodule

// File: tb/tb_ddr_frame_tracker.sv
// Directed bench for ddr_frame_tracker: DDR/SDR runs, odd lengths,
// zero-length error, abort, simultaneous strobes and async reset.
module tb_ddr_frame_tracker;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    ddr_frame_tracker_if #(.LEN_W(16), .CNT_W(5)) bus ();

    ddr_frame_tracker #(
        .DDR_WORD_BITS (20),
        .SDR_WORD_BITS (9),
        .LEN_W         (16),
        .CNT_W         (5)
    ) dut (
        .i_sys_clk (clk),
        .i_sys_rst (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic pos, input logic neg);
        bus.i_scl_pos_edge = pos;
        bus.i_scl_neg_edge = neg;
        tick(1);
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
    endtask

    task automatic edge_step(input string tag, input int e, input logic pos, input logic neg,
                             input int eb, input int ew, input logic ewd, input logic elast,
                             input logic ebusy, input logic exd);
        strobe(pos, neg);
        check($sformatf("%s e%0d bit", tag, e), 32'(bus.o_bit_count), 32'(eb));
        check($sformatf("%s e%0d word", tag, e), 32'(bus.o_word_count), 32'(ew));
        check($sformatf("%s e%0d word_done", tag, e), 32'(bus.o_word_done), 32'(ewd));
        check($sformatf("%s e%0d last_word", tag, e), 32'(bus.o_last_word), 32'(elast));
        check($sformatf("%s e%0d busy", tag, e), 32'(bus.o_busy), 32'(ebusy));
        check($sformatf("%s e%0d xfer_done", tag, e), 32'(bus.o_xfer_done), 32'(exd));
    endtask

    initial begin
        n_assert           = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        bus.i_en           = 1'b0;
        bus.i_mode         = 1'b0;
        bus.i_data_len     = '0;
        bus.i_scl_pos_edge = 1'b0;
        bus.i_scl_neg_edge = 1'b0;
        bus.i_err_rst      = 1'b0;

        // Reset state
        tick(2);
        check("rst bit", 32'(bus.o_bit_count), 32'd0);
        check("rst word", 32'(bus.o_word_count), 32'd0);
        check("rst busy", 32'(bus.o_busy), 32'd0);
        check("rst last", 32'(bus.o_last_word), 32'd0);
        check("rst done", 32'(bus.o_word_done | bus.o_xfer_done | bus.o_len_err), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // DDR, len 4 -> 2 words, alternating pos/neg every 4 clocks
        bus.i_mode     = 1'b1;
        bus.i_data_len = 16'd4;
        bus.i_en       = 1'b1;
        tick(1);
        check("ddr4 start busy", 32'(bus.o_busy), 32'd1);
        check("ddr4 start last", 32'(bus.o_last_word), 32'd0);
        for (int e = 1; e <= 40; e++) begin
            edge_step("ddr4", e, (e % 2) == 1, (e % 2) == 0, e % 20, (e >= 20) ? 1 : 0,
                      (e % 20) == 0, (e >= 20) && (e < 40), e < 40, e == 40);
            if (e < 40) begin
                tick(1);
                check($sformatf("ddr4 gap%0d word_done", e), 32'(bus.o_word_done), 32'd0);
                tick(2);
            end
        end
        tick(1);
        check("ddr4 post xfer_done", 32'(bus.o_xfer_done), 32'd0);
        check("ddr4 post word", 32'(bus.o_word_count), 32'd0);
        tick(3);
        check("ddr4 held en no restart", 32'(bus.o_busy), 32'd0);
        bus.i_en = 1'b0;
        tick(1);

        // SDR, len 3 with interleaved neg strobes; mode/len changes mid-run ignored
        bus.i_mode     = 1'b0;
        bus.i_data_len = 16'd3;
        bus.i_en       = 1'b1;
        tick(1);
        check("sdr3 start busy", 32'(bus.o_busy), 32'd1);
        for (int p = 1; p <= 27; p++) begin
            if (p == 10) begin
                bus.i_mode     = 1'b1;
                bus.i_data_len = 16'd0;
            end
            strobe(1'b0, 1'b1);
            check($sformatf("sdr3 neg%0d bit", p), 32'(bus.o_bit_count), 32'((p - 1) % 9));
            edge_step("sdr3", p, 1'b1, 1'b0, p % 9, (p < 9) ? 0 : ((p < 18) ? 1 : 2),
                      (p % 9) == 0, (p >= 18) && (p < 27), p < 27, p == 27);
        end
        bus.i_en = 1'b0;
        tick(2);

        // DDR, odd len 3 -> 2 words
        bus.i_mode     = 1'b1;
        bus.i_data_len = 16'd3;
        bus.i_en       = 1'b1;
        tick(1);
        for (int e = 1; e <= 40; e++) begin
            edge_step("ddr3", e, (e % 2) == 1, (e % 2) == 0, e % 20, (e >= 20) ? 1 : 0,
                      (e % 20) == 0, (e >= 20) && (e < 40), e < 40, e == 40);
        end
        bus.i_en = 1'b0;
        tick(2);

        // DDR, len 1 -> 1 word, last_word from the start
        bus.i_data_len = 16'd1;
        bus.i_en       = 1'b1;
        tick(1);
        check("ddr1 start last", 32'(bus.o_last_word), 32'd1);
        for (int e = 1; e <= 20; e++) begin
            edge_step("ddr1", e, (e % 2) == 1, (e % 2) == 0, e % 20, 0,
                      e == 20, e < 20, e < 20, e == 20);
        end
        bus.i_en = 1'b0;
        tick(2);

        // Zero length: one len_err pulse, no busy, no retrigger while held
        bus.i_data_len = 16'd0;
        bus.i_en       = 1'b1;
        tick(1);
        check("len0 err", 32'(bus.o_len_err), 32'd1);
        check("len0 busy", 32'(bus.o_busy), 32'd0);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check($sformatf("len0 hold%0d err", c), 32'(bus.o_len_err), 32'd0);
            check($sformatf("len0 hold%0d busy", c), 32'(bus.o_busy), 32'd0);
        end
        bus.i_en = 1'b0;
        tick(2);

        // err_rst beats a completing edge on a 1-word DDR transfer
        bus.i_data_len = 16'd1;
        bus.i_en       = 1'b1;
        tick(1);
        for (int e = 1; e <= 19; e++) begin
            strobe(1'b1, 1'b0);
        end
        check("prio pre bit", 32'(bus.o_bit_count), 32'd19);
        bus.i_err_rst = 1'b1;
        strobe(1'b1, 1'b0);
        check("prio word_done", 32'(bus.o_word_done), 32'd0);
        check("prio xfer_done", 32'(bus.o_xfer_done), 32'd0);
        check("prio busy", 32'(bus.o_busy), 32'd0);
        check("prio bit", 32'(bus.o_bit_count), 32'd0);
        bus.i_err_rst = 1'b0;
        bus.i_en      = 1'b0;
        tick(2);

        // DDR, len 8 (4 words), abort at bit 11 of word 2
        bus.i_data_len = 16'd8;
        bus.i_en       = 1'b1;
        tick(1);
        for (int e = 1; e <= 51; e++) begin
            strobe((e % 2) == 1, (e % 2) == 0);
        end
        check("abort pre bit", 32'(bus.o_bit_count), 32'd11);
        check("abort pre word", 32'(bus.o_word_count), 32'd2);
        bus.i_err_rst = 1'b1;
        tick(1);
        bus.i_err_rst = 1'b0;
        check("abort busy", 32'(bus.o_busy), 32'd0);
        check("abort bit", 32'(bus.o_bit_count), 32'd0);
        check("abort word", 32'(bus.o_word_count), 32'd0);
        check("abort done", 32'(bus.o_word_done | bus.o_xfer_done), 32'd0);
        tick(2);
        check("abort held en idle", 32'(bus.o_busy), 32'd0);
        bus.i_en = 1'b0;
        tick(1);
        bus.i_en = 1'b1;
        tick(1);
        check("restart busy", 32'(bus.o_busy), 32'd1);
        check("restart bit", 32'(bus.o_bit_count), 32'd0);
        strobe(1'b1, 1'b0);
        check("restart e1 bit", 32'(bus.o_bit_count), 32'd1);

        // Simultaneous pos+neg counts once
        strobe(1'b1, 1'b1);
        check("both bit", 32'(bus.o_bit_count), 32'd2);
        check("both word", 32'(bus.o_word_count), 32'd0);

        // Async reset mid-word clears outputs without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async bit", 32'(bus.o_bit_count), 32'd0);
        check("async busy", 32'(bus.o_busy), 32'd0);
        check("async word", 32'(bus.o_word_count), 32'd0);
        bus.i_en = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        check("post rst busy", 32'(bus.o_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_frame_tracker.md
Name: ddr_frame_tracker

Overview:
- Parametrised successor to the separate bit counter and frame counter in the HDR-DDR controller; merges both into one block.
- Tracks bit position within a word and word position within a transfer.
- Adds an SDR mode (9-bit words, rising SCL edge only) next to DDR (20-bit words, both SCL edges).
- Adds length latching, zero-length error reporting and mid-transfer abort; the DDR mode FSM drives it, and tx/rx consume its word and last-word strobes.

Parameters:
DDR_WORD_BITS, 20, bits per DDR word (2 preamble + 16 data + 2 parity)
SDR_WORD_BITS, 9, bits per SDR word (8 data + T bit)
LEN_W, 16, width of byte-length input and word counter
CNT_W, 5, bit counter width; must satisfy 2**CNT_W >= max(DDR_WORD_BITS, SDR_WORD_BITS)

Ports:
i_sys_clk  in  1  system clock
i_sys_rst  in  1  asynchronous active-low reset
i_en  in  1  start/hold; rising in IDLE starts a transfer, low while active aborts it
i_mode  in  1  0 = SDR, 1 = DDR; sampled at start
i_data_len  in  LEN_W  payload length in bytes; sampled at start
i_scl_pos_edge  in  1  one-cycle SCL rising-edge strobe
i_scl_neg_edge  in  1  one-cycle SCL falling-edge strobe
i_err_rst  in  1  synchronous abort, same effect as i_en low
o_bit_count  out  CNT_W  bit index within current word, 0-based
o_word_count  out  LEN_W  index of current data word, 0-based
o_word_done  out  1  one-cycle pulse: current word completed
o_last_word  out  1  high throughout the final data word
o_xfer_done  out  1  one-cycle pulse: all words completed
o_len_err  out  1  one-cycle pulse: start with i_data_len == 0
o_busy  out  1  high in COUNT state

Behaviour:
- Reset (async, i_sys_rst low): state IDLE, all outputs 0, latched mode and length cleared.
- FSM states: IDLE, COUNT, DONE, ERR.
- IDLE -> COUNT when i_en = 1 and i_err_rst = 0 and i_data_len != 0.
  - On this transition, latch mode; latch words_total = ceil(len/2) for DDR, len for SDR.
  - Clear both counters.
- IDLE -> ERR when i_en = 1 and i_data_len == 0.
- ERR: o_len_err = 1 for exactly one cycle, then IDLE.
  - Remains in IDLE until i_en is seen low, so a held i_en does not re-trigger.
- Counting edge in COUNT:
  - DDR: i_scl_pos_edge | i_scl_neg_edge; both strobes in the same cycle count as one edge.
  - SDR: i_scl_pos_edge only; i_scl_neg_edge ignored.
- On a counting edge:
  - If o_bit_count < WORD_BITS-1, increment o_bit_count.
  - Otherwise, o_bit_count wraps to 0 and o_word_done pulses the following cycle (registered, 1-cycle latency from the edge).
    - If o_word_count < words_total-1, o_word_count increments.
    - Else go to DONE.
- o_last_word = busy && (o_word_count == words_total-1); combinational from registers, glitch-free.
- DONE: o_xfer_done = 1 for one cycle; o_word_done pulses in the same cycle for the final word; then IDLE.
  - Restart requires i_en low for at least one cycle.
- Abort: i_en low or i_err_rst in COUNT.
  - Next cycle: IDLE, counters 0, no o_word_done, no o_xfer_done.
  - i_err_rst has priority over a simultaneous completing edge.
- i_mode or i_data_len changes while busy: ignored.
- Counters never exceed WORD_BITS-1 or words_total-1; no wrap past the final word.
- Odd DDR length: the last word carries one byte; the block counts the full 20 bits regardless.
- Max length 2**LEN_W-1: ceil computed in LEN_W bits without overflow, as (len>>1) + len[0].

Decomposition:
- Shared package ddr_pkg holds:
  - state encoding typedef (IDLE/COUNT/DONE/ERR);
  - mode constants MODE_SDR = 0, MODE_DDR = 1;
  - default word-size constants 20 and 9.
- One natural sub-module: ddr_word_len_calc. It is combinational: mode plus byte length in, words_total out. It is instantiated once and reused by the frame counter.

Test Plan:
- DDR, len = 4, 40 alternating pos/neg strobes every 4 clocks:
  - o_word_done pulses twice, after edges 20 and 40;
  - o_last_word high during edges 21..40;
  - o_xfer_done one cycle after edge 40;
  - o_busy drops the next cycle.
- SDR, len = 3, neg strobes interleaved:
  - only the 27 pos edges count;
  - word_done after pos edges 9, 18 and 27;
  - o_word_count sequence 0, 1, 2.
- DDR, len = 3 (odd) -> words_total = 2; 40 edges complete the transfer; len = 1 -> 1 word, o_last_word high from start.
- i_en = 1 with len = 0 -> single o_len_err pulse, o_busy stays 0; holding i_en high produces no second pulse.
- DDR, len = 8, i_err_rst asserted at bit 11 of word 2 -> next cycle IDLE, counters 0, no done pulses; restart runs cleanly from bit 0.
- Simultaneous pos and neg strobe in one cycle in DDR -> o_bit_count advances by 1; async reset asserted mid-word -> all outputs 0 immediately.
